// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: PC owner, req/ack fetch from instruction memory,
// valid/ready issue to decode, next-PC selection (seq/branch/jump) and fault trap.
module imem_fetch_ctrl #(
  parameter int unsigned              ADDR_SIZE = 32,
  parameter int unsigned              MEM_WIDTH = 32,
  parameter int unsigned              MEM_DEPTH = 1024,
  parameter logic [ADDR_SIZE-1:0]     RESET_PC  = {ADDR_SIZE{1'b0}},
  parameter int unsigned              TIMEOUT   = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 halt_req_i,
  output logic [ADDR_SIZE-1:0] imem_addr_o,
  output logic                 imem_req_o,
  input  logic                 imem_ack_i,
  input  logic [MEM_WIDTH-1:0] imem_rdata_i,
  output logic [MEM_WIDTH-1:0] instr_o,
  output logic [ADDR_SIZE-1:0] instr_pc_o,
  output logic                 instr_valid_o,
  input  logic                 instr_ready_i,
  input  logic                 br_taken_i,
  input  logic [15:0]          br_offset_i,
  input  logic                 jump_i,
  input  logic [25:0]          jump_target_i,
  output logic                 fault_o,
  output logic                 busy_o
);

  localparam int unsigned          CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [ADDR_SIZE-1:0] PC_LIMIT = ADDR_SIZE'(MEM_DEPTH * 4);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   pc_q, pc_d;
  logic [MEM_WIDTH-1:0]   instr_q, instr_d;
  logic [ADDR_SIZE-1:0]   instr_pc_q, instr_pc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   imem_req_q, instr_valid_q, fault_q, busy_q;

  logic [ADDR_SIZE-1:0]   pc4_s;
  logic [ADDR_SIZE-1:0]   br_target_s;
  logic [ADDR_SIZE-1:0]   jmp_target_s;
  logic [ADDR_SIZE-1:0]   next_pc_s;
  logic [CNT_W-1:0]       cnt_inc_s;

  // Next-PC candidates are formed from the issued instruction's own address.
  assign pc4_s        = instr_pc_q + ADDR_SIZE'(4);
  assign br_target_s  = pc4_s + {{(ADDR_SIZE-18){br_offset_i[15]}}, br_offset_i, 2'b00};
  assign jmp_target_s = {pc4_s[ADDR_SIZE-1:28], jump_target_i, 2'b00};
  assign cnt_inc_s    = cnt_q + CNT_W'(1);

  // Jump outranks a taken branch.
  always_comb begin
    if (jump_i) begin
      next_pc_s = jmp_target_s;
    end else if (br_taken_i) begin
      next_pc_s = br_target_s;
    end else begin
      next_pc_s = pc4_s;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    cnt_d      = {CNT_W{1'b0}};
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start_i && !halt_req_i) begin
          state_d = S_FETCH;
        end else begin
          state_d = state_q;
        end
      end
      S_FETCH: begin
        if (imem_ack_i) begin
          instr_d    = imem_rdata_i;
          instr_pc_d = pc_q;
          state_d    = S_ISSUE;
        end else if (cnt_inc_s == CNT_MAX) begin
          cnt_d   = cnt_inc_s;
          state_d = S_FAULT;
        end else begin
          cnt_d   = cnt_inc_s;
          state_d = S_FETCH;
        end
      end
      S_ISSUE: begin
        if (instr_ready_i) begin
          pc_d = next_pc_s;
          if (next_pc_s >= PC_LIMIT) begin
            state_d = S_FAULT;
          end else if (halt_req_i) begin
            state_d = S_HALT;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  // State, datapath and registered status outputs decoded from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= {MEM_WIDTH{1'b0}};
      instr_pc_q    <= {ADDR_SIZE{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      cnt_q         <= cnt_d;
      imem_req_q    <= (state_d == S_FETCH);
      instr_valid_q <= (state_d == S_ISSUE);
      fault_q       <= (state_d == S_FAULT);
      busy_q        <= (state_d == S_FETCH) || (state_d == S_ISSUE);
    end
  end

  assign imem_addr_o   = pc_q;
  assign imem_req_o    = imem_req_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign instr_valid_o = instr_valid_q;
  assign fault_o       = fault_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed sequences, a next-PC vector
// table and a randomized run against a transaction-level PC model.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_offset = 16'h0;
  logic        jump = 1'b0;
  logic [25:0] jump_target = 26'h0;
  logic        fault;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  // memory responder controls
  logic ack_en     = 1'b1;
  logic rand_delay = 1'b0;
  logic force_ack  = 1'b0;
  int   ack_delay  = 0;
  int   max_delay  = 6;
  int   cur_delay  = 0;
  int   wcnt       = 0;

  imem_fetch_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .halt_req_i(halt_req),
    .imem_addr_o(imem_addr), .imem_req_o(imem_req), .imem_ack_i(imem_ack),
    .imem_rdata_i(imem_rdata), .instr_o(instr), .instr_pc_o(instr_pc),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .br_taken_i(br_taken), .br_offset_i(br_offset), .jump_i(jump),
    .jump_target_i(jump_target), .fault_o(fault), .busy_o(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Memory: answers a held request after cur_delay wait cycles.
  always begin
    @(negedge clk);
    #1;
    if (force_ack) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
    end else if (imem_req && ack_en) begin
      if (wcnt >= cur_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = word_at(imem_addr);
        wcnt       = 0;
      end else begin
        imem_ack = 1'b0;
        wcnt     = wcnt + 1;
      end
    end else begin
      imem_ack  = 1'b0;
      wcnt      = 0;
      cur_delay = rand_delay ? int'($urandom_range(0, max_delay)) : ack_delay;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    start = 1'b0; halt_req = 1'b0; instr_ready = 1'b0;
    br_taken = 1'b0; br_offset = 16'h0; jump = 1'b0; jump_target = 26'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int maxc);
    int k;
    k = 0;
    while (!instr_valid && k < maxc) begin
      step();
      k++;
    end
    chk("wait_valid", {31'h0, instr_valid}, 32'h1);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  typedef struct {
    logic        jmp;
    logic        br;
    logic [15:0] off;
    logic [25:0] tgt;
    logic [31:0] cur_pc;
    logic [31:0] nxt;
    logic        flt;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [31:0] exp_pc, nxt, pc4;
    int issued, bt, jt, diff;
    logic pending;

    tbl[0]  = '{1'b0, 1'b0, 16'h7FFF, 26'h3,  32'h000, 32'h004, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 26'h0,  32'h004, 32'h008, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 16'h0010, 26'h0,  32'h008, 32'h00C, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 26'h0,  32'h00C, 32'h010, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 16'hFFFE, 26'h0,  32'h010, 32'h00C, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 16'h0000, 26'h12, 32'h00C, 32'h048, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 16'h0005, 26'h0E, 32'h048, 32'h038, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 16'h0003, 26'h0,  32'h038, 32'h048, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 16'h0100, 26'h5,  32'h048, 32'h04C, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 16'h03EB, 26'h0,  32'h04C, 32'hFFC, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 26'h0,  32'hFFC, 32'h1000, 1'b1};

    // Reset state
    do_reset();
    chk("rst_req",   {31'h0, imem_req},    32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_fault", {31'h0, fault},       32'h0);
    chk("rst_busy",  {31'h0, busy},        32'h0);
    chk("rst_addr",  imem_addr,            32'h0);
    chk("rst_instr", instr,                32'h0);
    chk("rst_ipc",   instr_pc,             32'h0);

    // IDLE ignores ack; halt_req blocks start
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    step();
    chk("idle_ack_valid", {31'h0, instr_valid}, 32'h0);
    chk("idle_ack_instr", instr, 32'h0);
    halt_req = 1'b1; start = 1'b1;
    step();
    halt_req = 1'b0; start = 1'b0;
    chk("idle_halt_blocks", {31'h0, imem_req}, 32'h0);

    // 0-wait throughput and start latency
    instr_ready = 1'b1;
    do_start();
    for (int k = 0; k < 3; k++) begin
      chk("seq_req",  {31'h0, imem_req}, 32'h1);
      chk("seq_addr", imem_addr, 32'(k * 4));
      chk("seq_busy", {31'h0, busy}, 32'h1);
      step();
      chk("seq_valid", {31'h0, instr_valid}, 32'h1);
      chk("seq_ipc",   instr_pc, 32'(k * 4));
      chk("seq_instr", instr, word_at(32'(k * 4)));
      if (k == 2) instr_ready = 1'b0;
      step();
    end
    // Consumer stall: held stable, no request
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", {31'h0, instr_valid}, 32'h1);
      chk("stall_ipc",   instr_pc, 32'h8);
      chk("stall_instr", instr, word_at(32'h8));
      chk("stall_req",   {31'h0, imem_req}, 32'h0);
      step();
    end
    instr_ready = 1'b1;
    step();
    chk("resume_req",  {31'h0, imem_req}, 32'h1);
    chk("resume_addr", imem_addr, 32'hC);
    // halt_req raised during FETCH takes effect after the consume
    halt_req = 1'b1;
    step();
    chk("halt_issue_valid", {31'h0, instr_valid}, 32'h1);
    step();
    chk("halt_req",   {31'h0, imem_req}, 32'h0);
    chk("halt_valid", {31'h0, instr_valid}, 32'h0);
    chk("halt_busy",  {31'h0, busy}, 32'h0);
    chk("halt_addr",  imem_addr, 32'h10);
    start = 1'b1;
    step();
    chk("halt_start_blocked", {31'h0, imem_req}, 32'h0);
    halt_req = 1'b0;
    step();
    start = 1'b0;
    chk("halt_restart_req",  {31'h0, imem_req}, 32'h1);
    chk("halt_restart_addr", imem_addr, 32'h10);

    // Next-PC vector table
    do_reset();
    do_start();
    for (int i = 0; i < 11; i++) begin
      wait_valid(20);
      chk("tbl_ipc",   instr_pc, tbl[i].cur_pc);
      chk("tbl_instr", instr, word_at(tbl[i].cur_pc));
      jump = tbl[i].jmp; br_taken = tbl[i].br;
      br_offset = tbl[i].off; jump_target = tbl[i].tgt;
      instr_ready = 1'b1;
      step();
      clear_inputs();
      chk("tbl_addr", imem_addr, tbl[i].nxt);
      chk("tbl_fault", {31'h0, fault}, {31'h0, tbl[i].flt});
      chk("tbl_req", {31'h0, imem_req}, {31'h0, ~tbl[i].flt});
    end
    // Fault is sticky and ignores start/halt
    start = 1'b1; halt_req = 1'b1;
    step();
    step();
    clear_inputs();
    chk("flt_sticky", {31'h0, fault}, 32'h1);
    chk("flt_busy",   {31'h0, busy}, 32'h0);
    chk("flt_addr",   imem_addr, 32'h1000);
    do_reset();
    chk("flt_rst_clear", {31'h0, fault}, 32'h0);

    // Timeout: 15 FETCH cycles without ack
    ack_en = 1'b0;
    do_start();
    for (int k = 0; k < 15; k++) begin
      chk("to_req",   {31'h0, imem_req}, 32'h1);
      chk("to_fault", {31'h0, fault}, 32'h0);
      step();
    end
    chk("to_fault_set", {31'h0, fault}, 32'h1);
    chk("to_req_off",   {31'h0, imem_req}, 32'h0);
    chk("to_addr",      imem_addr, 32'h0);
    ack_en = 1'b1;
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    chk("to_sticky", {31'h0, fault}, 32'h1);
    do_reset();
    chk("to_rst_clear", {31'h0, fault}, 32'h0);

    // Ack on the last legal FETCH cycle
    ack_delay = 14;
    do_start();
    wait_valid(30);
    chk("late_ack_fault", {31'h0, fault}, 32'h0);
    chk("late_ack_ipc",   instr_pc, 32'h0);
    ack_delay = 0;

    // rst mid-FETCH with a coincident ack is discarded
    do_reset();
    ack_en = 1'b0;
    do_start();
    step();
    rst = 1'b1; force_ack = 1'b1;
    step();
    rst = 1'b0; force_ack = 1'b0;
    ack_en = 1'b1;
    chk("rstf_req",   {31'h0, imem_req}, 32'h0);
    chk("rstf_busy",  {31'h0, busy}, 32'h0);
    chk("rstf_instr", instr, 32'h0);
    chk("rstf_valid", {31'h0, instr_valid}, 32'h0);
    step();
    chk("rstf_idle", {31'h0, imem_req}, 32'h0);

    // Randomized run against a PC-sequence model
    do_reset();
    rand_delay = 1'b1;
    do_start();
    exp_pc = 32'h0;
    issued = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_fault", {31'h0, fault}, 32'h0);
      chk("rnd_busy",  {31'h0, busy}, {31'h0, imem_req | instr_valid});
      pending = 1'b0;
      instr_ready = ($urandom_range(0, 2) != 0);
      jump        = ($urandom_range(0, 7) == 0);
      br_taken    = ($urandom_range(0, 3) == 0);
      jt          = int'($urandom_range(0, 1023));
      bt          = int'($urandom_range(0, 1023));
      jump_target = 26'(jt);
      br_offset   = 16'($urandom);
      nxt         = exp_pc;
      if (instr_valid) begin
        chk("rnd_ipc",   instr_pc, exp_pc);
        chk("rnd_instr", instr, word_at(exp_pc));
        pc4 = exp_pc + 32'h4;
        if (exp_pc == 32'hFFC) jump = 1'b1;
        diff = bt - int'(pc4 >> 2);
        br_offset = diff[15:0];
        if (jump)          nxt = 32'(jt * 4);
        else if (br_taken) nxt = 32'(bt * 4);
        else               nxt = pc4;
        pending = instr_ready;
      end
      step();
      if (pending) begin
        exp_pc = nxt;
        issued++;
      end
    end
    clear_inputs();
    rand_delay = 1'b0;
    chk("rnd_progress", {31'h0, issued >= 200}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
